scfifo_rd_stream_adapter: RTL
=============================

SCFIFO_RD_STREAM_ADAPTER -- requirements
Module: scfifo_rd_stream_adapter

Interface
REQ-001 Parameter WIDTH, default 20: data word width in bits, 1..256.
REQ-002 Parameter READ_LATENCY, default 1: cycles from upstream rdreq to valid upstream q, legal range 1..3.
REQ-003 Localparam DEPTH = READ_LATENCY+2: skid buffer entries. Localparam CW = clog2(DEPTH+1): counter width.
REQ-004 clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 sclr_n  in  1  reset; synchronous, active-low.
REQ-006 fifo_empty  in  1  upstream normal-mode FIFO empty flag.
REQ-007 fifo_q  in  WIDTH  upstream FIFO read data, valid READ_LATENCY cycles after rdreq.
REQ-008 fifo_rdreq  out  1  read request to upstream FIFO.
REQ-009 out_valid  out  1  downstream stream word available.
REQ-010 out_ready  in  1  downstream accepts word.
REQ-011 out_data  out  WIDTH  downstream stream word.
REQ-012 pending  out  CW  reads issued but not yet popped downstream (in flight plus buffered).
REQ-013 overrun_err  out  1  sticky: a returning word found the buffer full.

Function
REQ-014 Design converts fixed-latency rdreq/q FIFO reads into a valid/ready stream without bubbles.
REQ-015 fifo_rdreq = sclr_n & ~fifo_empty & (pending < DEPTH); it has no combinational dependence on out_ready.
REQ-016 Block never asserts fifo_rdreq while fifo_empty=1, so it never underflows the FIFO.
REQ-017 In-flight tracker: READ_LATENCY-bit shift register; bit 0 loads fifo_rdreq each cycle; the MSB, when set, marks fifo_q valid this cycle.
REQ-018 Capture: when tracker MSB=1, fifo_q is written to buf[wr_ptr]; wr_ptr advances modulo DEPTH; occ increments.
REQ-019 out_valid = (occ != 0); out_data = buf[rd_ptr]. Both are driven from registers only.
REQ-020 Pop: when out_valid & out_ready, rd_ptr advances modulo DEPTH and occ decrements.
REQ-021 Simultaneous capture and pop: occ unchanged, both pointers advance. Capture into an empty buffer makes the word visible on the next cycle, not the same cycle.
REQ-022 pending next = pending + fifo_rdreq - (out_valid & out_ready); arithmetic is CW-bit unsigned and never wraps.
REQ-023 Invariant: pending = occ + popcount(tracker) <= DEPTH at all times.
REQ-024 Steady state: with fifo_empty=0 and out_ready=1 held, throughput is one word per cycle after a fill latency of READ_LATENCY+1 cycles.
REQ-025 With out_ready=0 held, pending saturates at DEPTH, fifo_rdreq deasserts, and all issued words land in the buffer without loss.
REQ-026 Ordering: words leave in exactly the order read from the FIFO; no duplication and no drop.
REQ-027 overrun_err sets if a capture occurs while occ=DEPTH and there is no pop that cycle; it holds until reset. It is unreachable in correct operation.
REQ-028 out_valid, once asserted, stays asserted with out_data stable until popped.

Reset
REQ-029 While sclr_n=0 at a clock edge, the following are cleared: tracker=0, occ=0, wr_ptr=0, rd_ptr=0, pending=0, overrun_err=0, all buf entries=0.
REQ-030 While sclr_n=0, fifo_rdreq=0 combinationally; out_valid=0 and out_data=0 from the first edge with sclr_n low.
REQ-031 Reset mid-operation discards in-flight and buffered words. The upstream FIFO is reset by the system in the same cycle; the block does not resynchronise with it.
REQ-032 Operation resumes on the first edge with sclr_n=1; the first fifo_rdreq can assert in that cycle.

Verification
REQ-033 READ_LATENCY=1, FIFO preloaded with 0x1..0x8, out_ready=1 -> fifo_rdreq high 8 consecutive cycles; out_valid first high 2 cycles after first rdreq; out_data 0x1..0x8 on 8 consecutive cycles.
REQ-034 READ_LATENCY=1, FIFO full, out_ready=0 -> exactly 3 rdreqs issued; pending=3; occ=3. Then out_ready=1 -> data in order, no gap after first word.
REQ-035 READ_LATENCY=3, random fifo_empty and out_ready, 10k words -> scoreboard match, overrun_err=0, pending<=5 always.
REQ-036 fifo_empty=1 throughout -> fifo_rdreq never asserts, out_valid=0, pending=0.
REQ-037 Reset pulse (one cycle sclr_n=0) with pending=3 and out_valid=1 -> next cycle pending=0, out_valid=0, out_data=0, overrun_err=0.
REQ-038 Hold out_valid=1, out_ready=0 for 20 cycles -> out_data unchanged every cycle.

Source files
------------

// File: rtl/scfifo_rd_stream_adapter.sv
// Turns fixed-latency rdreq/q reads from a normal-mode FIFO into a bubble-free
// valid/ready stream, using a small skid buffer sized to cover the read latency.
module scfifo_rd_stream_adapter #(
    parameter int  WIDTH        = 20,
    parameter int  READ_LATENCY = 1,
    localparam int DEPTH        = READ_LATENCY + 2,
    localparam int CW           = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             sclr_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_q,
    output logic             fifo_rdreq,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    pending,
    output logic             overrun_err
);

    localparam int              PW       = $clog2(DEPTH);
    localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);

    // Downstream handshake: a word transfers on every rising edge where
    // out_valid & out_ready; out_valid never drops and out_data never changes
    // until that transfer happens, and out_valid does not depend on out_ready.

    logic [READ_LATENCY-1:0] trk_q, trk_d;
    logic [WIDTH-1:0]        mem_q [DEPTH];
    logic [WIDTH-1:0]        mem_d [DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           occ_q, occ_d;
    logic [CW-1:0]           pending_q, pending_d;
    logic                    overrun_q, overrun_d;

    logic capture;
    logic pop;
    logic full;
    logic wr_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Read issue is gated only by credit (pending), never by out_ready, so the
    // request path stays short and the buffer always has room for what returns.
    assign fifo_rdreq  = sclr_n & ~fifo_empty & (pending_q < DEPTH_C);
    assign capture     = trk_q[READ_LATENCY-1];
    assign out_valid   = (occ_q != '0);
    assign out_data    = mem_q[rd_ptr_q];
    assign pending     = pending_q;
    assign overrun_err = overrun_q;

    assign pop   = out_valid & out_ready;
    assign full  = (occ_q == DEPTH_C);
    // A full buffer can still take a word when the head leaves in the same cycle.
    assign wr_en = capture & (~full | pop);

    always_comb begin
        trk_d    = '0;
        trk_d[0] = fifo_rdreq;
        for (int i = 1; i < READ_LATENCY; i++) begin
            trk_d[i] = trk_q[i-1];
        end

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = fifo_q;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end

        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        occ_d = occ_q;
        case ({wr_en, pop})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase

        pending_d = pending_q;
        case ({fifo_rdreq, pop})
            2'b10:   pending_d = pending_q + CW'(1);
            2'b01:   pending_d = pending_q - CW'(1);
            default: pending_d = pending_q;
        endcase

        overrun_d = overrun_q | (capture & full & ~pop);
    end

    always_ff @(posedge clock) begin
        if (!sclr_n) begin
            trk_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            pending_q <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            trk_q     <= trk_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            mem_q     <= mem_d;
        end
    end

endmodule
